// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-ported data memory between the core memory stage and a DMA/debug port.
// Define DMEM_ARB_STARVE_EN to let a DMA request blocked for WAIT_MAX cycles steal one core cycle.
module dmem_port_arbiter #(
    parameter int unsigned WAIT_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_en_m,
    input  logic        core_we_m,
    input  logic [31:0] core_addr_m,
    input  logic [31:0] core_wdata_m,
    output logic [31:0] core_rdata_m,
    output logic        stall_m,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic [31:0] mem_a,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic {
        SHARE = 1'b0,
        STEAL = 1'b1
    } state_t;

    if (WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_bad_wait_max
        $error("dmem_port_arbiter: WAIT_MAX must be in 1..255");
    end

    state_t      state_q, state_d;
    logic        stall_q, stall_d;
    logic        dma_rvalid_q, dma_rvalid_d;
    logic [31:0] dma_rdata_q, dma_rdata_d;
    logic        gnt;
    logic        we;

    // Memory port mux; address/data default to the core so idle cycles look like core reads.
    always_comb begin
        mem_a  = core_addr_m;
        mem_wd = core_wdata_m;
        we     = 1'b0;
        gnt    = 1'b0;
        unique case (state_q)
            SHARE: begin
                if (core_en_m) begin
                    we = core_we_m;
                end else if (dma_req) begin
                    mem_a  = dma_addr;
                    mem_wd = dma_wdata;
                    we     = dma_we;
                    gnt    = 1'b1;
                end
            end
            STEAL: begin
                mem_a  = dma_addr;
                mem_wd = dma_wdata;
                if (dma_req) begin
                    we  = dma_we;
                    gnt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign mem_we       = we & rst;
    assign dma_gnt      = gnt & rst;
    assign core_rdata_m = mem_rd;

    always_comb begin
        dma_rvalid_d = gnt & ~dma_we;
        dma_rdata_d  = (gnt && !dma_we) ? mem_rd : dma_rdata_q;
    end

`ifdef DMEM_ARB_STARVE_EN
    logic [7:0] wait_cnt_q, wait_cnt_d;

    // Steal is decided on the last blocked edge so the grant lands in the very next cycle.
    always_comb begin
        wait_cnt_d = '0;
        state_d    = SHARE;
        if (dma_req && !gnt) begin
            wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
            if (state_q == SHARE && wait_cnt_q == 8'(WAIT_MAX - 1)) begin
                state_d = STEAL;
            end
        end
        stall_d = (state_d == STEAL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    always_comb begin
        state_d = SHARE;
        stall_d = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= SHARE;
            stall_q      <= 1'b0;
            dma_rvalid_q <= 1'b0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            stall_q      <= stall_d;
            dma_rvalid_q <= dma_rvalid_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign stall_m    = stall_q;
    assign dma_rvalid = dma_rvalid_q;
    assign dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter with a behavioural combinational-read data memory.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_en_m, core_we_m;
    logic [31:0] core_addr_m, core_wdata_m, core_rdata_m;
    logic        stall_m;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] dma_rdata;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wd;
    } gnt_exp_t;

    gnt_exp_t    gnt_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] mem [0:63];

    dmem_port_arbiter #(.WAIT_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .core_en_m(core_en_m), .core_we_m(core_we_m),
        .core_addr_m(core_addr_m), .core_wdata_m(core_wdata_m),
        .core_rdata_m(core_rdata_m), .stall_m(stall_m),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
    end
    assign mem_rd = mem[mem_a[7:2]];
    always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: every grant and every read-valid pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (dma_gnt) begin
                if (gnt_q.size() == 0) begin
                    chk("unexpected_gnt", 32'd1, 32'd0);
                end else begin
                    gnt_exp_t e;
                    e = gnt_q.pop_front();
                    chk("gnt_mem_a", mem_a, e.addr);
                    chk("gnt_mem_we", {31'd0, mem_we}, {31'd0, e.we});
                    if (e.we) chk("gnt_mem_wd", mem_wd, e.wd);
                end
            end
            if (dma_rvalid) begin
                if (rd_q.size() == 0) chk("unexpected_rvalid", 32'd1, 32'd0);
                else chk("dma_rdata", dma_rdata, rd_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        core_en_m = 1'b1; core_we_m = 1'b1; core_addr_m = 32'h0; core_wdata_m = 32'h0;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h0; dma_wdata = 32'h0;
        #7;
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_dma_gnt", {31'd0, dma_gnt}, 32'd0);
        chk("rst_stall", {31'd0, stall_m}, 32'd0);
        chk("rst_rvalid", {31'd0, dma_rvalid}, 32'd0);
        chk("rst_rdata", dma_rdata, 32'd0);
        #5 rst = 1'b1;
        step();

        // Core store wins over a pending DMA read.
        core_en_m = 1'b1; core_we_m = 1'b1; core_addr_m = 32'h10; core_wdata_m = 32'hDEADBEEF;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h10;
        at_neg();
        chk("core_mem_we", {31'd0, mem_we}, 32'd1);
        chk("core_mem_a", mem_a, 32'h10);
        chk("core_dma_gnt", {31'd0, dma_gnt}, 32'd0);
        step();

        core_we_m = 1'b0; dma_req = 1'b0;
        at_neg();
        chk("core_read", core_rdata_m, 32'hDEADBEEF);
        step();

        // Idle-cycle DMA read, then back-to-back write and read-back.
        core_en_m = 1'b0; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h10;
        gnt_q.push_back('{32'h10, 1'b0, 32'h0});
        rd_q.push_back(32'hDEADBEEF);
        at_neg();
        chk("idle_gnt", {31'd0, dma_gnt}, 32'd1);
        step();
        dma_we = 1'b1; dma_addr = 32'h24; dma_wdata = 32'h1234;
        gnt_q.push_back('{32'h24, 1'b1, 32'h1234});
        step();
        dma_we = 1'b0;
        gnt_q.push_back('{32'h24, 1'b0, 32'h0});
        rd_q.push_back(32'h1234);
        step();
        dma_req = 1'b0;
        step();
        step();
        chk("rdata_hold", dma_rdata, 32'h1234);
        chk("rvalid_low", {31'd0, dma_rvalid}, 32'd0);

        // Starvation: core busy every cycle, DMA write 0x55 -> 0x20.
        core_en_m = 1'b1; core_we_m = 1'b0; core_addr_m = 32'h30;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'h55;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk("blocked_gnt", {31'd0, dma_gnt}, 32'd0);
            chk("blocked_stall", {31'd0, stall_m}, 32'd0);
            step();
        end
`ifdef DMEM_ARB_STARVE_EN
        gnt_q.push_back('{32'h20, 1'b1, 32'h55});
        at_neg();
        chk("steal_stall", {31'd0, stall_m}, 32'd1);
        chk("steal_gnt", {31'd0, dma_gnt}, 32'd1);
        chk("steal_mem_a", mem_a, 32'h20);
        step();
        dma_req = 1'b0;
        at_neg();
        chk("after_steal_stall", {31'd0, stall_m}, 32'd0);
        step();
`else
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk("nosteal_gnt", {31'd0, dma_gnt}, 32'd0);
            chk("nosteal_stall", {31'd0, stall_m}, 32'd0);
            step();
        end
        core_en_m = 1'b0;
        gnt_q.push_back('{32'h20, 1'b1, 32'h55});
        at_neg();
        chk("idle_release_gnt", {31'd0, dma_gnt}, 32'd1);
        step();
        dma_req = 1'b0;
        step();
`endif
        core_en_m = 1'b1; core_we_m = 1'b0; core_addr_m = 32'h20;
        at_neg();
        chk("dma_write_landed", core_rdata_m, 32'h55);
        step();

`ifdef DMEM_ARB_STARVE_EN
        // Reset in the middle of a STEAL cycle, then a fresh full wait before the next steal.
        core_addr_m = 32'h30;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h28; dma_wdata = 32'h77;
        for (int i = 0; i < 4; i++) step();
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_stall", {31'd0, stall_m}, 32'd0);
        chk("async_rst_gnt", {31'd0, dma_gnt}, 32'd0);
        #1 rst = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("post_rst_blocked", {31'd0, dma_gnt}, 32'd0);
            chk("post_rst_stall", {31'd0, stall_m}, 32'd0);
            step();
        end
        gnt_q.push_back('{32'h28, 1'b1, 32'h77});
        at_neg();
        chk("post_rst_steal", {31'd0, stall_m}, 32'd1);
        step();
        dma_req = 1'b0;
        step();
`endif

        core_en_m = 1'b0;
        step();
        step();
        chk("gnt_queue_empty", gnt_q.size(), 32'd0);
        chk("rd_queue_empty", rd_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single-ported data memory between the pipeline's memory-access stage (core) and a secondary DMA/debug requester. The core has priority, and the DMA port uses cycles where the core does not access memory. With starvation protection compiled in, a DMA request blocked for `WAIT_MAX` cycles takes one memory cycle from the core, and the block asserts a registered stall to the pipeline for that cycle. It sits between the memory-stage logic and `data_memory_module` and drives that memory's `A`, `WE` and `WD` inputs.

## Interface
- `WAIT_MAX`, default 4: number of consecutive blocked DMA cycles before a steal; legal range 1..255.
- `clk` input, 1: clock; all state updates on the rising edge.
- `rst` input, 1: reset, asynchronous, active-low; clock `clk`.
- `core_en_m` input, 1: core accesses memory this cycle (load or store).
- `core_we_m` input, 1: core access is a store (MemWriteM).
- `core_addr_m` input, 32: core address (ALUResultM).
- `core_wdata_m` input, 32: core store data (WriteDataM).
- `core_rdata_m` output, 32: `mem_rd` passed straight through to the pipeline.
- `stall_m` output, 1: registered; the pipeline must hold its memory-stage register and must not advance the writeback register this cycle.
- `dma_req` input, 1: DMA access request; must stay high until `dma_gnt`.
- `dma_we` input, 1: DMA access is a write.
- `dma_addr` input, 32: DMA address.
- `dma_wdata` input, 32: DMA write data.
- `dma_gnt` output, 1: combinational; the memory serves the DMA request this cycle.
- `dma_rvalid` output, 1: registered; pulses one cycle after a granted DMA read.
- `dma_rdata` output, 32: registered read data; holds until the next granted DMA read.
- `mem_a` output, 32: data memory address.
- `mem_we` output, 1: data memory write enable.
- `mem_wd` output, 32: data memory write data.
- `mem_rd` input, 32: data memory read data; combinational read.

## Operation
- The FSM has two states, SHARE and STEAL. Registers: `state`, `wait_cnt` (8 bits), `dma_rvalid`, `dma_rdata`.
- SHARE, `core_en_m`=1: the core owns the memory. `mem_a`=`core_addr_m`, `mem_wd`=`core_wdata_m`, `mem_we`=`core_we_m`, `dma_gnt`=0.
- SHARE, `core_en_m`=0 and `dma_req`=1: the DMA owns the memory. `mem_*` come from the `dma_*` inputs, `mem_we`=`dma_we`, `dma_gnt`=1.
- SHARE, both requests idle: `mem_a` follows the core, `mem_we`=0.
- `wait_cnt`:
  - increments (saturating) on each cycle with `dma_req`=1 and `dma_gnt`=0;
  - clears on any cycle with `dma_gnt`=1 or `dma_req`=0.
- SHARE to STEAL: taken at the edge where the DMA is blocked and `wait_cnt`==`WAIT_MAX`-1. This happens only when `DMEM_ARB_STARVE_EN` is defined.
- STEAL: `stall_m`=1 and the DMA owns the memory. If `dma_req`=1, `dma_gnt`=1 and `mem_we`=`dma_we`. STEAL always returns to SHARE on the next edge, and `wait_cnt` clears.
- If `dma_req` drops while in STEAL (protocol violation), the cycle is idle: `mem_we`=0 and `dma_gnt`=0. `stall_m` stays 1 because it is registered and cannot be retracted.
- A granted DMA read (`dma_we`=0) captures `mem_rd` into `dma_rdata` and sets `dma_rvalid` for the next cycle. A granted DMA write does not pulse `dma_rvalid`.
- The core store path is never gated in SHARE. While `stall_m`=1, the pipeline re-presents the same memory-stage access on the next cycle, so the core store executes exactly once.

## Timing
- Reset values: `state`=SHARE, `wait_cnt`=0, `stall_m`=0, `dma_rvalid`=0, `dma_rdata`=0. While `rst`=0, `mem_we` and `dma_gnt` are forced to 0.
- Core access latency: 0. `core_rdata_m` is valid in the same cycle, as the pipeline already expects.
- DMA read latency: `dma_rvalid` and `dma_rdata` appear one cycle after `dma_gnt`.
- Worst-case DMA wait with steal enabled: `WAIT_MAX` blocked cycles, then the grant in the following (STEAL) cycle.
- Back-to-back DMA grants are allowed on consecutive idle core cycles. STEAL never occurs on two consecutive cycles.
- When `dma_req` rises in the same cycle that the core goes idle, the DMA is granted that cycle and `wait_cnt` stays 0.
- If reset asserts mid-STEAL, the block returns to SHARE asynchronously and drops `stall_m` immediately.

## Configuration
- `DMEM_ARB_STARVE_EN` defined: the STEAL state, `wait_cnt` and `stall_m` generation are present.
- Not defined: `stall_m` is tied to 0, the FSM stays in SHARE, and `wait_cnt` logic is removed. The DMA is served only in core-idle cycles and can starve indefinitely.

## Test plan
- Reset: hold `rst`=0 with `dma_req`=1 and `core_en_m`=1 → `mem_we`=0, `dma_gnt`=0, `stall_m`=0, `dma_rvalid`=0, `dma_rdata`=0.
- Core priority: `core_en_m`=1, `core_we_m`=1, address 0x10, data 0xDEADBEEF, with `dma_req`=1 → `mem_we`=1, `mem_a`=0x10, `dma_gnt`=0; a later core read of 0x10 returns 0xDEADBEEF.
- Idle-cycle DMA read: `core_en_m`=0, `dma_req`=1, `dma_we`=0, `dma_addr`=0x10 → `dma_gnt`=1 the same cycle; next cycle `dma_rvalid`=1 and `dma_rdata`=0xDEADBEEF.
- Starvation with `WAIT_MAX`=4 and the macro defined: `core_en_m`=1 continuously, DMA write of 0x55 to address 0x20 → blocked for 4 cycles, then in the 5th cycle `stall_m`=1, `dma_gnt`=1, `mem_a`=0x20; in the 6th cycle `stall_m`=0 and `wait_cnt`=0.
- Same stimulus without the macro → `stall_m` never rises and `dma_gnt` stays 0 until `core_en_m` drops.
- Asynchronous reset asserted mid-STEAL → `stall_m`=0 immediately; after release, the next DMA grant occurs only in a core-idle cycle or after a fresh `WAIT_MAX` count.
